// File: rtl/rm_pkg.sv
// Shared types for the runtime-monitor lane: select-table entry and record FSM states.
package rm_pkg;

   localparam int RM_SYM_W     = 8;
   // Widest event index a select entry can hold; lanes up to 256 events.
   localparam int RM_EV_IW_MAX = 8;

   typedef struct packed {
      logic                    force_zero;
      logic [RM_EV_IW_MAX-1:0] idx;
   } sel_entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } rec_state_e;

endpackage

// File: rtl/rm_first_hit.sv
// First-violation recorder: lowest-index priority encode, valid/ready record, saturating drop count.
module rm_first_hit
   import rm_pkg::*;
#(
   parameter  int NUM_RULES = 256,
   parameter  int TS_W      = 32,
   parameter  int DROP_W    = 8,
   localparam int RULE_IW   = $clog2(NUM_RULES)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clr_i,
   input  logic [NUM_RULES-1:0] hit_i,
   input  logic [TS_W-1:0]      ts_i,
   input  logic                 ready_i,
   output logic                 valid_o,
   output logic [RULE_IW-1:0]   idx_o,
   output logic [TS_W-1:0]      ts_o,
   output logic [DROP_W-1:0]    drop_o,
   output rec_state_e           state_o
);

   // Handshake: a record is transferred in any cycle where valid_o and ready_i are both high;
   // idx_o/ts_o stay stable while valid_o is high and ready_i is low.

   function automatic logic [RULE_IW-1:0] lowest_set(input logic [NUM_RULES-1:0] v);
      lowest_set = '0;
      for (int i = NUM_RULES - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = RULE_IW'(i);
      end
   endfunction

   rec_state_e          r_state;
   logic                r_valid;
   logic [RULE_IW-1:0]  r_idx;
   logic [TS_W-1:0]     r_ts;
   logic [DROP_W-1:0]   r_drop;
   logic                w_any;
   logic [RULE_IW-1:0]  w_first;

   assign w_any   = |hit_i;
   assign w_first = lowest_set(hit_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_ts    <= '0;
         r_drop  <= '0;
      end else if (clr_i) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_ts    <= '0;
         r_drop  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state <= PEND;
                  r_valid <= 1'b1;
                  r_idx   <= w_first;
                  r_ts    <= ts_i;
               end
            end
            PEND: begin
               if (ready_i) begin
                  // A hit in the consuming cycle becomes the next record, not a drop.
                  if (w_any) begin
                     r_idx <= w_first;
                     r_ts  <= ts_i;
                  end else begin
                     r_state <= IDLE;
                     r_valid <= 1'b0;
                  end
               end else if (w_any && (r_drop != '1)) begin
                  r_drop <= r_drop + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign valid_o = r_valid;
   assign idx_o   = r_idx;
   assign ts_o    = r_ts;
   assign drop_o  = r_drop;
   assign state_o = r_state;

endmodule

// File: rtl/rm_lane_prog.sv
// Runtime-monitor lane: programmable event-to-symbol routing for NUM_CH checker engines,
// engine run/reset generation and sticky/first-violation collection of their rule outputs.
module rm_lane_prog
   import rm_pkg::*;
#(
   parameter  int NUM_EVENTS   = 32,
   parameter  int NUM_CH       = 16,
   parameter  int SYM_W        = RM_SYM_W,
   parameter  int RULES_PER_CH = 16,
   parameter  int TS_W         = 32,
   parameter  int DROP_W       = 8,
   localparam int NUM_RULES    = NUM_CH * RULES_PER_CH,
   localparam int EV_IW        = $clog2(NUM_EVENTS),
   localparam int RULE_IW      = $clog2(NUM_RULES),
   localparam int CH_IW        = $clog2(NUM_CH),
   localparam int BIT_IW       = $clog2(SYM_W)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    lane_reset_i,
   input  logic                    ev_valid_i,
   input  logic [NUM_EVENTS-1:0]   lane_vector_i,
   input  logic                    cfg_we_i,
   input  logic [CH_IW-1:0]        cfg_ch_i,
   input  logic [BIT_IW-1:0]       cfg_bit_i,
   input  logic [EV_IW:0]          cfg_sel_i,
   input  logic [NUM_RULES-1:0]    rule_en_i,
   output logic [NUM_CH*SYM_W-1:0] ch_symbols_o,
   output logic [NUM_CH-1:0]       ch_run_o,
   output logic [NUM_CH-1:0]       ch_reset_o,
   input  logic [NUM_RULES-1:0]    ch_rule_i,
   output logic [NUM_RULES-1:0]    viol_sticky_o,
   output logic                    viol_valid_o,
   input  logic                    viol_ready_i,
   output logic [RULE_IW-1:0]      viol_idx_o,
   output logic [TS_W-1:0]         viol_ts_o,
   output logic [DROP_W-1:0]       drop_cnt_o,
   output rec_state_e              rec_state_o
);

   sel_entry_t              r_tab [NUM_CH][SYM_W];
   logic [NUM_EVENTS-1:0]   r_lane_q;
   logic [NUM_CH-1:0]       r_run;
   logic                    r_run_d;
   logic [NUM_CH-1:0]       r_chrst;
   logic [NUM_RULES-1:0]    r_sticky;
   logic [TS_W-1:0]         r_ts;
   logic                    w_wr_ok;
   sel_entry_t              w_wr_entry;
   logic [NUM_CH*SYM_W-1:0] w_sym;
   logic [NUM_RULES-1:0]    w_hit;

   assign w_wr_ok = cfg_we_i && !lane_reset_i
                 && ({1'b0, cfg_ch_i} < (CH_IW+1)'(NUM_CH))
                 && ({1'b0, cfg_sel_i[EV_IW-1:0]} < (EV_IW+1)'(NUM_EVENTS));

   assign w_wr_entry.force_zero = cfg_sel_i[EV_IW];
   assign w_wr_entry.idx        = RM_EV_IW_MAX'(cfg_sel_i[EV_IW-1:0]);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < SYM_W; b++) begin
               r_tab[c][b] <= '{force_zero: 1'b1, idx: '0};
            end
         end
      end else if (w_wr_ok) begin
         r_tab[cfg_ch_i][cfg_bit_i] <= w_wr_entry;
      end
   end

   // Range guard on read keeps any stale wide index from selecting past the lane vector.
   always_comb begin
      w_sym = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int b = 0; b < SYM_W; b++) begin
            if (!r_tab[c][b].force_zero && (int'(r_tab[c][b].idx) < NUM_EVENTS)) begin
               w_sym[c*SYM_W + b] = r_lane_q[r_tab[c][b].idx[EV_IW-1:0]];
            end
         end
      end
   end

   // Engines advance on ch_run_o; their rule outputs are valid the cycle after.
   assign w_hit = (r_run_d && !lane_reset_i) ? (ch_rule_i & rule_en_i) : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lane_q <= '0;
         r_run    <= '0;
         r_run_d  <= 1'b0;
         r_chrst  <= '0;
         r_sticky <= '0;
         r_ts     <= '0;
      end else begin
         r_ts <= r_ts + 1'b1;
         if (lane_reset_i) begin
            r_run    <= '0;
            r_run_d  <= 1'b0;
            r_chrst  <= '1;
            r_sticky <= '0;
         end else begin
            r_run    <= {NUM_CH{ev_valid_i}};
            r_run_d  <= r_run[0];
            r_sticky <= r_sticky | w_hit;
            r_chrst  <= '0;
            if (ev_valid_i) r_lane_q <= lane_vector_i;
            if (w_wr_ok) r_chrst[cfg_ch_i] <= 1'b1;
         end
      end
   end

   rm_first_hit #(
      .NUM_RULES (NUM_RULES),
      .TS_W      (TS_W),
      .DROP_W    (DROP_W)
   ) u_first_hit (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (lane_reset_i),
      .hit_i   (w_hit),
      .ts_i    (r_ts),
      .ready_i (viol_ready_i),
      .valid_o (viol_valid_o),
      .idx_o   (viol_idx_o),
      .ts_o    (viol_ts_o),
      .drop_o  (drop_cnt_o),
      .state_o (rec_state_o)
   );

   assign ch_symbols_o  = w_sym;
   assign ch_run_o      = r_run;
   assign ch_reset_o    = r_chrst;
   assign viol_sticky_o = r_sticky;

endmodule

// File: tb/tb_rm_lane_prog.sv
// Directed bench for rm_lane_prog: default lane plus a small non-power-of-two lane for range checks.
module tb_rm_lane_prog;
   import rm_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] tb_ts;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_ts <= '0;
      else        tb_ts <= tb_ts + 1;
   end

   // ---------------- main lane (defaults) ----------------
   logic          lane_reset, ev_valid, cfg_we, viol_ready;
   logic [31:0]   lane_vec;
   logic [3:0]    cfg_ch;
   logic [2:0]    cfg_bit;
   logic [5:0]    cfg_sel;
   logic [255:0]  rule_en, ch_rule;
   logic [127:0]  ch_symbols;
   logic [15:0]   ch_run, ch_reset;
   logic [255:0]  sticky;
   logic          viol_valid;
   logic [7:0]    viol_idx;
   logic [31:0]   viol_ts;
   logic [7:0]    drop_cnt;
   rec_state_e    rec_state;

   rm_lane_prog u_dut (
      .clk_i(clk), .rst_ni(rst_n), .lane_reset_i(lane_reset), .ev_valid_i(ev_valid),
      .lane_vector_i(lane_vec), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_bit_i(cfg_bit),
      .cfg_sel_i(cfg_sel), .rule_en_i(rule_en), .ch_symbols_o(ch_symbols), .ch_run_o(ch_run),
      .ch_reset_o(ch_reset), .ch_rule_i(ch_rule), .viol_sticky_o(sticky), .viol_valid_o(viol_valid),
      .viol_ready_i(viol_ready), .viol_idx_o(viol_idx), .viol_ts_o(viol_ts), .drop_cnt_o(drop_cnt),
      .rec_state_o(rec_state)
   );

   // ---------------- range lane: 40 events, 12 channels ----------------
   logic          b_lane_reset, b_ev_valid, b_cfg_we, b_ready;
   logic [39:0]   b_lane_vec;
   logic [3:0]    b_cfg_ch;
   logic [2:0]    b_cfg_bit;
   logic [6:0]    b_cfg_sel;
   logic [191:0]  b_rule_en, b_rule;
   logic [95:0]   b_symbols;
   logic [11:0]   b_run, b_reset;
   logic [191:0]  b_sticky;
   logic          b_valid;
   logic [7:0]    b_idx;
   logic [31:0]   b_ts;
   logic [7:0]    b_drop;
   rec_state_e    b_state;

   rm_lane_prog #(.NUM_EVENTS(40), .NUM_CH(12)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .lane_reset_i(b_lane_reset), .ev_valid_i(b_ev_valid),
      .lane_vector_i(b_lane_vec), .cfg_we_i(b_cfg_we), .cfg_ch_i(b_cfg_ch), .cfg_bit_i(b_cfg_bit),
      .cfg_sel_i(b_cfg_sel), .rule_en_i(b_rule_en), .ch_symbols_o(b_symbols), .ch_run_o(b_run),
      .ch_reset_o(b_reset), .ch_rule_i(b_rule), .viol_sticky_o(b_sticky), .viol_valid_o(b_valid),
      .viol_ready_i(b_ready), .viol_idx_o(b_idx), .viol_ts_o(b_ts), .drop_cnt_o(b_drop),
      .rec_state_o(b_state)
   );

   // ---------------- scoreboard ----------------
   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   logic [255:0] exp_sticky;
   logic [31:0]  exp_ts;

   // ---------------- stimulus ----------------
   initial begin
      lane_reset = 0; ev_valid = 0; cfg_we = 0; viol_ready = 0;
      lane_vec = '0; cfg_ch = '0; cfg_bit = '0; cfg_sel = '0; rule_en = '0; ch_rule = '0;
      b_lane_reset = 0; b_ev_valid = 0; b_cfg_we = 0; b_ready = 0;
      b_lane_vec = '0; b_cfg_ch = '0; b_cfg_bit = '0; b_cfg_sel = '0; b_rule_en = '0; b_rule = '0;

      tick(2);
      chk("rst_symbols", ch_symbols, 0);
      chk("rst_run", ch_run, 0);
      chk("rst_chreset", ch_reset, 0);
      chk("rst_sticky", sticky, 0);
      chk("rst_valid", viol_valid, 0);
      chk("rst_idx", viol_idx, 0);
      chk("rst_ts", viol_ts, 0);
      chk("rst_drop", drop_cnt, 0);
      rst_n = 1'b1;

      // ch0 bit b <- event b; each write pulses ch_reset_o[0] the next cycle
      for (int b = 0; b < 8; b++) begin
         cfg_we = 1; cfg_ch = 4'd0; cfg_bit = 3'(b); cfg_sel = {1'b0, 5'(b)};
         tick();
         chk("cfg_chreset_pulse", ch_reset, 16'h0001);
      end
      cfg_we = 0;
      tick();
      chk("cfg_chreset_end", ch_reset, 0);

      ev_valid = 1; lane_vec = 32'h0000_00A5;
      tick();
      chk("ev_symbols", ch_symbols, 128'hA5);
      chk("ev_run", ch_run, 16'hFFFF);
      ev_valid = 0; lane_vec = 32'h0000_00FF;
      tick();
      chk("idle_run", ch_run, 0);
      chk("idle_symbols_hold", ch_symbols, 128'hA5);

      // range lane: event 40 and channel 13 are out of range there
      b_ev_valid = 1; b_lane_vec = '1;
      b_cfg_we = 1; b_cfg_ch = 4'd3; b_cfg_bit = 3'd2; b_cfg_sel = 7'd40;
      tick();
      chk("oor_ev_noreset", b_reset, 0);
      chk("oor_ev_table", b_symbols, 0);
      b_ev_valid = 0; b_cfg_ch = 4'd13; b_cfg_bit = 3'd0; b_cfg_sel = 7'd39;
      tick();
      chk("oor_ch_noreset", b_reset, 0);
      chk("oor_ch_table", b_symbols, 0);
      b_cfg_ch = 4'd3; b_cfg_bit = 3'd2; b_cfg_sel = 7'd39;
      tick();
      chk("inr_reset", b_reset, 12'h008);
      chk("inr_symbols", b_symbols, 96'h1 << 26);
      b_cfg_we = 0;
      tick();
      chk("inr_reset_end", b_reset, 0);

      // first violation at ts=100
      ev_valid = 1; rule_en = '1;
      for (int i = 0; i < 300 && tb_ts != 32'd100; i++) tick();
      ch_rule = (256'h1 << 5) | (256'h1 << 17);
      tick();
      exp_sticky = (256'h1 << 5) | (256'h1 << 17);
      chk("first_valid", viol_valid, 1);
      chk("first_idx", viol_idx, 5);
      chk("first_ts", viol_ts, 100);
      chk("first_sticky", sticky, exp_sticky);
      chk("first_state", rec_state, PEND);
      chk("first_drop", drop_cnt, 0);

      tick(10);
      chk("drop_10", drop_cnt, 10);
      tick(290);
      ch_rule = '0;
      chk("drop_sat", drop_cnt, 255);
      tick();
      chk("drop_hold", drop_cnt, 255);
      chk("pend_idx", viol_idx, 5);
      chk("pend_ts", viol_ts, 100);
      chk("pend_valid", viol_valid, 1);

      // consume with a same-cycle hit on rule 9
      viol_ready = 1; ch_rule = 256'h1 << 9; exp_ts = tb_ts;
      tick();
      exp_sticky = exp_sticky | (256'h1 << 9);
      chk("rearm_valid", viol_valid, 1);
      chk("rearm_idx", viol_idx, 9);
      chk("rearm_ts", viol_ts, exp_ts);
      chk("rearm_drop", drop_cnt, 255);
      chk("rearm_sticky", sticky, exp_sticky);
      ch_rule = '0;
      tick();
      chk("consume_valid", viol_valid, 0);
      chk("consume_state", rec_state, IDLE);
      viol_ready = 0;

      // lane reset discards same-cycle hit and cfg write
      lane_reset = 1; ch_rule = 256'h1 << 3;
      cfg_we = 1; cfg_ch = 4'd1; cfg_bit = 3'd0; cfg_sel = 6'd0;
      tick();
      lane_reset = 0; ch_rule = '0; cfg_we = 0;
      chk("lrst_chreset", ch_reset, 16'hFFFF);
      chk("lrst_sticky", sticky, 0);
      chk("lrst_valid", viol_valid, 0);
      chk("lrst_drop", drop_cnt, 0);
      chk("lrst_run", ch_run, 0);
      tick();
      chk("lrst_chreset_end", ch_reset, 0);
      chk("lrst_table_kept", ch_symbols, 128'hFF);
      tick();

      // masked rule produces nothing
      rule_en = ~(256'h1 << 5); ch_rule = 256'h1 << 5;
      tick();
      chk("mask_valid", viol_valid, 0);
      chk("mask_sticky", sticky, 0);
      ch_rule = 256'h1 << 2; exp_ts = tb_ts;
      tick();
      ch_rule = '0;
      chk("post_idx", viol_idx, 2);
      chk("post_ts_kept", viol_ts, exp_ts);
      chk("post_sticky", sticky, 256'h1 << 2);

      lane_reset = 1;
      tick();
      lane_reset = 0;
      chk("lrst2_chreset", ch_reset, 16'hFFFF);
      chk("lrst2_sticky", sticky, 0);
      chk("lrst2_valid", viol_valid, 0);

      // no sampling without run
      ev_valid = 0; rule_en = '1;
      tick(2);
      ch_rule = '1;
      tick(3);
      chk("norun_valid", viol_valid, 0);
      chk("norun_sticky", sticky, 0);

      // async reset in the middle of a pending record
      ev_valid = 1;
      tick(3);
      chk("pre_arst_valid", viol_valid, 1);
      #2 rst_n = 0;
      #1;
      chk("arst_valid", viol_valid, 0);
      chk("arst_sticky", sticky, 0);
      chk("arst_symbols", ch_symbols, 0);
      chk("arst_run", ch_run, 0);
      ch_rule = '0; ev_valid = 0;
      tick();
      rst_n = 1;
      tick(2);
      chk("post_arst_valid", viol_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
